// File: rtl/tnn_seq_pkg.sv
// ---------------------------------------------------------------------------
// tnn_seq_pkg
// Shared constants, trit encoding, FSM state type and the popcount clamp
// helper for the ternary-neuron popcount sequencer.
// ---------------------------------------------------------------------------
package tnn_seq_pkg;

    localparam int CHUNK_W = 21;   // inputs per popcount operand
    localparam int PC_W    = 5;    // popcount result width
    localparam int PC_MAX  = 21;   // largest legal popcount value

    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Approximate popcount units may report 22..31; saturate at 21.
    function automatic logic [PC_W-1:0] clamp_cnt(input logic [PC_W-1:0] cnt);
        if (cnt > PC_W'(PC_MAX)) begin
            return PC_W'(PC_MAX);
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/tnn_chunk_sel.sv
// ---------------------------------------------------------------------------
// tnn_chunk_sel
// Chooses the 21-bit chunk fed to the shared popcount unit.
//   Default build        : chunk picked by index idx_i; last_o at CHUNKS-1.
//   TNN_ZERO_SKIP_EN set : chunk is the lowest set bit of mask_i; mask_rem_o
//                          is mask_i with that bit cleared; last_o when no
//                          nonzero chunk remains after this one.
// Ports:
//   data_i     in  captured CHUNKS*21 operand bus of the active polarity
//   idx_i      in  chunk index (default build only)
//   mask_i     in  nonzero-chunk mask (zero-skip build only)
//   mask_rem_o out mask after consuming the selected chunk (zero-skip only)
//   chunk_o    out selected chunk (0 when nothing is selected)
//   sel_vld_o  out a chunk was selected this cycle
//   last_o     out this is the final cycle of the phase
// ---------------------------------------------------------------------------
module tnn_chunk_sel
    import tnn_seq_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int IDX_W  = 2
) (
    input  logic [CHUNKS*CHUNK_W-1:0] data_i,
`ifdef TNN_ZERO_SKIP_EN
    input  logic [CHUNKS-1:0]         mask_i,
    output logic [CHUNKS-1:0]         mask_rem_o,
`else
    input  logic [IDX_W-1:0]          idx_i,
`endif
    output logic [CHUNK_W-1:0]        chunk_o,
    output logic                      sel_vld_o,
    output logic                      last_o
);

`ifdef TNN_ZERO_SKIP_EN
    logic found_s;

    // Priority pick of the lowest-index nonzero chunk (AND-OR mux).
    always_comb begin
        chunk_o    = '0;
        mask_rem_o = mask_i;
        found_s    = 1'b0;
        for (int k = 0; k < CHUNKS; k++) begin
            chunk_o       = chunk_o | (data_i[k*CHUNK_W +: CHUNK_W] &
                                       {CHUNK_W{mask_i[k] & ~found_s}});
            mask_rem_o[k] = mask_i[k] & found_s;
            found_s       = found_s | mask_i[k];
        end
        sel_vld_o = |mask_i;
        last_o    = ~|mask_rem_o;
    end
`else
    // Indexed chunk mux; fixed schedule always consumes a chunk.
    always_comb begin
        chunk_o = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            chunk_o = chunk_o | (data_i[k*CHUNK_W +: CHUNK_W] &
                                 {CHUNK_W{idx_i == IDX_W'(k)}});
        end
        sel_vld_o = 1'b1;
        last_o    = (idx_i == IDX_W'(CHUNKS-1));
    end
`endif

endmodule

// File: rtl/tnn_popcount_seq.sv
// ---------------------------------------------------------------------------
// tnn_popcount_seq
// Sequencer for one ternary neuron with CHUNKS*21 inputs. Time-multiplexes an
// external 21-input popcount unit over the positive then negative chunks,
// accumulates both counts, forms pos-neg and thresholds it into a trit.
// Optional build macro: TNN_ZERO_SKIP_EN (skip all-zero chunks).
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake (accepted only in IDLE)
//   in_pos, in_neg      masked inputs, chunk k = bits [21k+20:21k]
//   thr_hi, thr_lo      signed thresholds (thr_hi tested first)
//   pc_a / pc_cnt       operand to / same-cycle result from popcount unit
//   out_valid/out_ready result handshake
//   out_sum             signed pos-neg count
//   out_trit            01=+1, 00=0, 11=-1
// ---------------------------------------------------------------------------
module tnn_popcount_seq
    import tnn_seq_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int ACC_W  = $clog2(CHUNK_W*CHUNKS+1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNKS*CHUNK_W-1:0] in_pos,
    input  logic [CHUNKS*CHUNK_W-1:0] in_neg,
    input  logic [ACC_W:0]            thr_hi,
    input  logic [ACC_W:0]            thr_lo,
    output logic [CHUNK_W-1:0]        pc_a,
    input  logic [PC_W-1:0]           pc_cnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W:0]            out_sum,
    output logic [1:0]                out_trit
);

    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int DW    = CHUNKS*CHUNK_W;

    state_e               state_q;
    logic [DW-1:0]        pos_q, neg_q;
    logic signed [ACC_W:0] thr_hi_q, thr_lo_q;
    logic [ACC_W-1:0]     acc_pos_q, acc_neg_q;
    logic                 in_ready_q, out_valid_q;
    logic [ACC_W:0]       out_sum_q;
    logic [1:0]           out_trit_q;

    logic [DW-1:0]        sel_data_d;
    logic [CHUNK_W-1:0]   chunk_d;
    logic                 sel_vld_d, last_d, busy_d;
    logic [PC_W-1:0]      cnt_d;
    logic [ACC_W-1:0]     acc_pos_d, acc_neg_d;
    logic signed [ACC_W:0] sum_d;
    logic [1:0]           trit_d;

`ifdef TNN_ZERO_SKIP_EN
    logic [CHUNKS-1:0]    mask_pos_q, mask_neg_q;
    logic [CHUNKS-1:0]    mask_d, mask_rem_d, nz_pos_d, nz_neg_d;
`else
    logic [IDX_W-1:0]     idx_q;
`endif

    assign busy_d     = (state_q == ST_POS) || (state_q == ST_NEG);
    assign sel_data_d = (state_q == ST_NEG) ? neg_q : pos_q;

`ifdef TNN_ZERO_SKIP_EN
    assign mask_d = (state_q == ST_NEG) ? mask_neg_q : mask_pos_q;

    // Per-chunk nonzero flags of the incoming operands, registered at capture.
    always_comb begin
        nz_pos_d = '0;
        nz_neg_d = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            nz_pos_d[k] = |in_pos[k*CHUNK_W +: CHUNK_W];
            nz_neg_d[k] = |in_neg[k*CHUNK_W +: CHUNK_W];
        end
    end
`endif

    tnn_chunk_sel #(
        .CHUNKS (CHUNKS),
        .IDX_W  (IDX_W)
    ) u_chunk_sel (
        .data_i     (sel_data_d),
`ifdef TNN_ZERO_SKIP_EN
        .mask_i     (mask_d),
        .mask_rem_o (mask_rem_d),
`else
        .idx_i      (idx_q),
`endif
        .chunk_o    (chunk_d),
        .sel_vld_o  (sel_vld_d),
        .last_o     (last_d)
    );

    // An empty zero-skip phase drives pc_a=0 and must add nothing, whatever
    // the popcount unit returns.
    assign cnt_d     = sel_vld_d ? clamp_cnt(pc_cnt) : '0;
    assign acc_pos_d = acc_pos_q + ACC_W'(cnt_d);
    assign acc_neg_d = acc_neg_q + ACC_W'(cnt_d);
    assign sum_d     = $signed({1'b0, acc_pos_q}) - $signed({1'b0, acc_neg_d});

    // Trit decision on the final difference; upper threshold has priority.
    always_comb begin
        if (sum_d >= thr_hi_q) begin
            trit_d = TRIT_POS;
        end else if (sum_d < thr_lo_q) begin
            trit_d = TRIT_NEG;
        end else begin
            trit_d = TRIT_ZERO;
        end
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            neg_q       <= '0;
            thr_hi_q    <= '0;
            thr_lo_q    <= '0;
            acc_pos_q   <= '0;
            acc_neg_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_trit_q  <= TRIT_ZERO;
`ifdef TNN_ZERO_SKIP_EN
            mask_pos_q  <= '0;
            mask_neg_q  <= '0;
`else
            idx_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        pos_q      <= in_pos;
                        neg_q      <= in_neg;
                        thr_hi_q   <= thr_hi;
                        thr_lo_q   <= thr_lo;
                        acc_pos_q  <= '0;
                        acc_neg_q  <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_POS;
`ifdef TNN_ZERO_SKIP_EN
                        mask_pos_q <= nz_pos_d;
                        mask_neg_q <= nz_neg_d;
`else
                        idx_q      <= '0;
`endif
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_POS: begin
                    acc_pos_q <= acc_pos_d;
`ifdef TNN_ZERO_SKIP_EN
                    mask_pos_q <= mask_rem_d;
`else
                    idx_q <= last_d ? '0 : idx_q + IDX_W'(1);
`endif
                    if (last_d) begin
                        state_q <= ST_NEG;
                    end else begin
                        state_q <= ST_POS;
                    end
                end
                ST_NEG: begin
                    acc_neg_q <= acc_neg_d;
`ifdef TNN_ZERO_SKIP_EN
                    mask_neg_q <= mask_rem_d;
`else
                    idx_q <= last_d ? '0 : idx_q + IDX_W'(1);
`endif
                    if (last_d) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_sum_q   <= sum_d;
                        out_trit_q  <= trit_d;
                    end else begin
                        state_q <= ST_NEG;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_trit  = out_trit_q;
    assign pc_a      = busy_d ? chunk_d : '0;

endmodule

// File: doc/tnn_popcount_seq.md
Name: tnn_popcount_seq

Overview:
- Sequencer for one ternary neuron with CHUNKS*21 inputs. It time-multiplexes a single shared 21-input popcount unit (exact or approximate variant, instantiated outside this block) over the positive-weight and negative-weight chunks.
- Accumulates both counts, forms the signed difference, and thresholds it into a trit.
- Sits between the input-masking stage (x AND w+ / x AND w-) and the neuron output register bank.

Parameters:
- CHUNKS, 4, number of 21-bit chunks per polarity (>=1).
- ACC_W, $clog2(21*CHUNKS+1), width of each unsigned accumulator (7 for default).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operands.
- in_pos  in  CHUNKS*21  positive-masked inputs; chunk k = bits [21k+20:21k].
- in_neg  in  CHUNKS*21  negative-masked inputs.
- thr_hi  in  ACC_W+1  signed upper threshold.
- thr_lo  in  ACC_W+1  signed lower threshold.
- pc_a  out  21  operand driven to the shared popcount unit.
- pc_cnt  in  5  popcount result; combinational return in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W+1  signed pos-neg.
- out_trit  out  2  01=+1, 00=0, 11=-1.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; accumulators, chunk index, capture registers, out_sum and out_trit = 0; out_valid=0; pc_a=0; in_ready=0.
  - in_ready goes to 1 in the first cycle after rst deasserts.
- FSM states: IDLE, POS, NEG, DONE.
- IDLE:
  - in_ready=1, pc_a=0.
  - On in_valid&&in_ready: register in_pos, in_neg, thr_hi, thr_lo; clear acc_pos, acc_neg; idx=0; go to POS.
- POS:
  - pc_a = captured pos chunk idx.
  - acc_pos += clamp(pc_cnt, 21) each cycle, where values 22..31 (possible from approximate units) are clamped to 21.
  - idx increments; at idx=CHUNKS-1, set idx=0 and go to NEG.
- NEG: same as POS, on neg chunks into acc_neg. At the last chunk go to DONE, registering:
  - out_sum = acc_pos - (acc_neg + final clamped count), signed ACC_W+1, cannot overflow.
  - out_trit = 01 if out_sum >= thr_hi; else 11 if out_sum < thr_lo; else 00. thr_hi is tested first, so thr_lo > thr_hi is legal and deterministic.
- DONE:
  - out_valid=1; out_sum and out_trit held stable; in_ready=0; pc_a=0.
  - On out_ready, go to IDLE.
- Latency: out_valid rises exactly 2*CHUNKS clock edges after the accepting edge. Throughput is one result per 2*CHUNKS+2 cycles minimum. No overlap of transactions.
- in_valid is ignored outside IDLE. Input buses are don't-care after capture.
- out_ready is ignored outside DONE.
- rst asserted mid-operation aborts immediately; the partial result is never emitted.

Optional Feature:
- Macro TNN_ZERO_SKIP_EN.
- Defined:
  - At capture, per-chunk nonzero masks are registered.
  - Each POS/NEG cycle processes the lowest-index unprocessed nonzero chunk and clears its mask bit.
  - The phase ends when no nonzero chunk remains after the current cycle.
  - A phase with no nonzero chunks takes 1 cycle with pc_a=0 and adds 0.
  - Latency = max(1,nz_pos)+max(1,nz_neg) edges.
  - pc_a stays at 0 for skipped chunks, to reduce toggling in printed logic.
- Undefined: fixed schedule as above, no mask registers.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package tnn_seq_pkg holds:
  - CHUNK_W=21, PC_W=5, PC_MAX=21.
  - Trit encoding constants TRIT_POS, TRIT_ZERO, TRIT_NEG.
  - State enum type.
  - Clamp function.
- One sub-module, tnn_chunk_sel, contains the chunk multiplexer plus the zero-skip priority selector (which is present only under TNN_ZERO_SKIP_EN). It outputs the selected chunk and the last-chunk flag.

Test Plan (CHUNKS=4, exact popcount model unless stated):
- Reset: assert rst mid-cycle -> out_valid=0, out_trit=00, out_sum=0, pc_a=0, in_ready=0 immediately; in_ready=1 one cycle after release.
- in_pos=all ones, in_neg=0, thr_hi=10, thr_lo=-10 -> out_valid exactly 8 edges after accept; out_sum=84, out_trit=01.
- in_pos with 5 bits set (chunk 0), in_neg with 9 bits set spread over chunks 1 and 3, thr_hi=3, thr_lo=-3 -> out_sum=-4, out_trit=11.
- Popcount model stuck at 31, thr_hi=1, thr_lo=-1 -> counts clamped to 21 per chunk, pos=neg=84, out_sum=0, out_trit=00.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid, out_sum, out_trit stable; in_ready=0; no capture. Release -> IDLE next cycle, then a new accept works.
- With TNN_ZERO_SKIP_EN: in_pos nonzero only in chunk 2, in_neg=0 -> out_valid after 2 edges, pc_a=0 in the NEG cycle; rst during POS aborts with no out_valid.
